// File: rtl/booth_pkg.sv
// Shared types and encodings for the radix-2 Booth multiplier controller.
package booth_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      OP    = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   localparam int         CYC_W   = 5;
   localparam logic [4:0] CYC_MAX = 5'd31;

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: synchronous clear/enable, flags the final iteration.
module booth_iter_cnt #(
   parameter int W     = 8,
   parameter int CNT_W = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count; the controller only enables counting below W-1, so no wrap occurs.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier control FSM (IDLE/LOAD/OP/SHIFT/DONE).
// Optional cycle counter output enabled by macro BOOTH_CTRL_CYCLE_CNT_EN.
module booth_ctrl
   import booth_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       q0,
   input  logic       q_1,
   output logic [1:0] sel_a,
   output logic [1:0] sel_q,
   output logic       ld_m,
   output logic       clr_a,
   output logic       add_sub,
   output logic       ready,
   output logic       done
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
   ,
   output logic [CYC_W-1:0] cycles
`endif
);

   state_e state_q;
   state_e state_d;
   logic   cnt_clr;
   logic   cnt_en;
   logic   cnt_last;

   booth_iter_cnt #(
      .W     (W),
      .CNT_W (CNT_W)
   ) u_iter_cnt (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .last_o (cnt_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode; OP also looks at the Booth pair {q0,q_1}
   always_comb begin
      state_d = state_q;
      sel_a   = SEL_HOLD;
      sel_q   = SEL_HOLD;
      ld_m    = 1'b0;
      clr_a   = 1'b0;
      add_sub = ADD;
      ready   = 1'b0;
      done    = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            ld_m    = 1'b1;
            sel_q   = SEL_LOAD;
            sel_a   = SEL_LOAD;
            clr_a   = 1'b1;
            cnt_clr = 1'b1;
            state_d = OP;
         end
         OP: begin
            case ({q0, q_1})
               2'b10: begin
                  sel_a   = SEL_LOAD;
                  add_sub = SUB;
                  state_d = SHIFT;
               end
               2'b01: begin
                  sel_a   = SEL_LOAD;
                  add_sub = ADD;
                  state_d = SHIFT;
               end
               default: begin
                  // No add needed: shift immediately to save a cycle
                  sel_a = SEL_SHR;
                  sel_q = SEL_SHR;
                  if (cnt_last) begin
                     state_d = DONE;
                  end else begin
                     cnt_en  = 1'b1;
                     state_d = OP;
                  end
               end
            endcase
         end
         SHIFT: begin
            sel_a = SEL_SHR;
            sel_q = SEL_SHR;
            if (cnt_last) begin
               state_d = DONE;
            end else begin
               cnt_en  = 1'b1;
               state_d = OP;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef BOOTH_CTRL_CYCLE_CNT_EN
   logic [CYC_W-1:0] cyc_q;
   logic [CYC_W-1:0] cyc_d;

   // Cleared on entry to LOAD so it reads the LOAD..DONE span once back in IDLE
   always_comb begin
      cyc_d = cyc_q;
      if (state_q == IDLE) begin
         if (start) begin
            cyc_d = 5'd0;
         end else begin
            cyc_d = cyc_q;
         end
      end else if (cyc_q == CYC_MAX) begin
         cyc_d = cyc_q;
      end else begin
         cyc_d = cyc_q + 5'd1;
      end
   end

   // Cycle counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= 5'd0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign cycles = cyc_q;
`endif

endmodule
